// File: rtl/prim_pad_attr_ctrl.sv
// prim_pad_attr_ctrl: sequences masked per-pad attribute writes, settle gaps and re-strobe sweeps.
// Optional macro PRIM_PAD_ATTR_CTRL_ERR_EN: out-of-range error pulse plus onehot0 strobe check.
module prim_pad_attr_ctrl #(
  parameter int NumPads      = 16,
  parameter int AttrDw       = 13,
  parameter int SettleCycles = 4,
  localparam int IdxW        = $clog2(NumPads)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumPads*AttrDw-1:0] warl_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [IdxW-1:0]           req_idx_i,
  input  logic [AttrDw-1:0]         req_attr_i,
  input  logic                      sweep_req_i,
  input  logic [IdxW-1:0]           rd_idx_i,
  output logic [AttrDw-1:0]         rd_attr_o,
  output logic [NumPads*AttrDw-1:0] attr_o,
  output logic [NumPads-1:0]        attr_upd_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int CntW =
    (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SettleCycles);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPads - 1);
  localparam logic [IdxW:0]   PadsW   = (IdxW + 1)'(NumPads);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SWEEP
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]           sidx_q, sidx_d;
  logic [NumPads*AttrDw-1:0] attr_q, attr_d;
  logic [NumPads-1:0]        upd_q, upd_d;
  logic                      pend_q, pend_d;
  logic                      accept;
  logic                      in_rng;

  assign req_ready_o = (state_q == IDLE) && !pend_q;
  assign accept      = req_valid_i && req_ready_o;
  assign in_rng      = {1'b0, req_idx_i} < PadsW;
  assign attr_o      = attr_q;
  assign attr_upd_o  = upd_q;
  assign busy_o      = (state_q != IDLE) || pend_q;

  // Next-state: masked writes, settle countdown, sweep walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sidx_d  = sidx_q;
    attr_d  = attr_q;
    upd_d   = '0;
    pend_d  = pend_q | sweep_req_i;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < NumPads; i++) begin
            if (in_rng && req_idx_i == IdxW'(i)) begin
              attr_d[i*AttrDw +: AttrDw] =
                req_attr_i & warl_i[i*AttrDw +: AttrDw];
              upd_d[i] = 1'b1;
            end
          end
          if (in_rng && SettleCycles > 0) begin
            state_d = SETTLE;
            cnt_d   = CntInit;
          end
        end else if (pend_q) begin
          state_d = SWEEP;
          sidx_d  = '0;
          pend_d  = sweep_req_i;
        end
      end
      SETTLE: begin
        if (cnt_q <= CntOne) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SWEEP: begin
        for (int i = 0; i < NumPads; i++) begin
          if (sidx_q == IdxW'(i)) upd_d[i] = 1'b1;
        end
        if (sidx_q == LastIdx) begin
          if (SettleCycles > 0) begin
            state_d = SETTLE;
            cnt_d   = CntInit;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sidx_d = sidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sidx_q  <= '0;
      attr_q  <= '0;
      upd_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sidx_q  <= sidx_d;
      attr_q  <= attr_d;
      upd_q   <= upd_d;
      pend_q  <= pend_d;
    end
  end

  // Readback mux; out-of-range index reads zero.
  always_comb begin
    rd_attr_o = '0;
    for (int i = 0; i < NumPads; i++) begin
      if (rd_idx_i == IdxW'(i)) begin
        rd_attr_o = attr_q[i*AttrDw +: AttrDw];
      end
    end
  end

`ifdef PRIM_PAD_ATTR_CTRL_ERR_EN
  logic err_q;

  // Error pulse one cycle after an out-of-range accept.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !in_rng;
    end
  end

  assign err_o = err_q;

  // At most one pad strobed per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(upd_q));
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_pad_attr_ctrl.sv
// tb_prim_pad_attr_ctrl: directed bench for the pad attribute sequencer.
// Two instances: 16 pads / settle 4, and 12 pads / settle 0.
module tb_prim_pad_attr_ctrl;

  localparam int AW = 13;
`ifdef PRIM_PAD_ATTR_CTRL_ERR_EN
  localparam logic ErrOn = 1'b1;
`else
  localparam logic ErrOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic [16*AW-1:0] warl0, attr0;
  logic v0, rdy0, sw0, busy0, err0;
  logic [3:0] idx0, rdi0;
  logic [AW-1:0] a0, rda0;
  logic [15:0] upd0;

  logic [12*AW-1:0] warl1, attr1;
  logic v1, rdy1, sw1, busy1, err1;
  logic [3:0] idx1, rdi1;
  logic [AW-1:0] a1, rda1;
  logic [11:0] upd1;

  int checks = 0;
  int errors = 0;
  logic [207:0] e0, e1;

  always #5 clk = ~clk;

  prim_pad_attr_ctrl #(
    .NumPads(16), .AttrDw(AW), .SettleCycles(4)
  ) d0 (
    .clk_i(clk), .rst_ni(rst_n), .warl_i(warl0),
    .req_valid_i(v0), .req_ready_o(rdy0),
    .req_idx_i(idx0), .req_attr_i(a0),
    .sweep_req_i(sw0), .rd_idx_i(rdi0),
    .rd_attr_o(rda0), .attr_o(attr0),
    .attr_upd_o(upd0), .busy_o(busy0), .err_o(err0)
  );

  prim_pad_attr_ctrl #(
    .NumPads(12), .AttrDw(AW), .SettleCycles(0)
  ) d1 (
    .clk_i(clk), .rst_ni(rst_n), .warl_i(warl1),
    .req_valid_i(v1), .req_ready_o(rdy1),
    .req_idx_i(idx1), .req_attr_i(a1),
    .sweep_req_i(sw1), .rd_idx_i(rdi1),
    .rd_attr_o(rda1), .attr_o(attr1),
    .attr_upd_o(upd1), .busy_o(busy1), .err_o(err1)
  );

  task automatic chk(input string tag,
                     input logic [207:0] obs,
                     input logic [207:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes0(input int pa, input int pb);
    for (int p = 0; p < 16; p++) begin
      tick();
      chk("sweep_strobe", upd0, 16'h1 << p);
      sw0 = (p == pa) || (p == pb);
    end
    sw0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 0; sw0 = 0; idx0 = 0; rdi0 = 0; a0 = 0;
    v1 = 0; sw1 = 0; idx1 = 0; rdi1 = 0; a1 = 0;
    for (int i = 0; i < 16; i++) warl0[i*AW +: AW] = 13'h1FFF;
    warl0[3*AW +: AW] = 13'h0003;
    warl0[5*AW +: AW] = 13'h1F0F;
    for (int i = 0; i < 12; i++) warl1[i*AW +: AW] = 13'h1FFF;
    warl1[1*AW +: AW] = 13'h00FF;
    e0 = '0;
    e1 = '0;

    tick();
    tick();
    chk("rst_attr", attr0, '0);
    chk("rst_upd", upd0, '0);
    chk("rst_err", err0, 1'b0);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    tick();

    v0 = 1; idx0 = 3; a0 = 13'h1FFF; rdi0 = 3;
    tick();
    v0 = 0;
    e0[3*AW +: AW] = 13'h0003;
    chk("t1_attr", attr0, e0);
    chk("t1_upd", upd0, 16'h0008);
    chk("t1_rd", rda0, 13'h0003);
    chk("t1_ready_lo", rdy0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_upd_clr", upd0, '0);
      chk("t1_settle", rdy0, 1'b0);
    end
    tick();
    chk("t1_ready_back", rdy0, 1'b1);
    chk("t1_busy", busy0, 1'b0);

    sw0 = 1;
    tick();
    sw0 = 0;
    chk("t3_ready", rdy0, 1'b0);
    chk("t3_busy", busy0, 1'b1);
    tick();
    chk("t3_pre", upd0, '0);
    strobes0(-1, -1);
    chk("t3_attr_keep", attr0, e0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_settle_busy", busy0, 1'b1);
      chk("t3_settle_upd", upd0, '0);
    end
    tick();
    chk("t3_idle", busy0, 1'b0);
    chk("t3_ready_back", rdy0, 1'b1);

    v0 = 1; idx0 = 5; a0 = 13'h0AAA; sw0 = 1; rdi0 = 5;
    tick();
    v0 = 0; sw0 = 0;
    e0[5*AW +: AW] = 13'h0A0A;
    chk("t4_upd", upd0, 16'h0020);
    chk("t4_attr", attr0, e0);
    chk("t4_rd", rda0, 13'h0A0A);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_gap", upd0, '0);
      chk("t4_busy", busy0, 1'b1);
    end
    strobes0(3, 8);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_gap2", upd0, '0);
      chk("t4_busy2", busy0, 1'b1);
    end
    strobes0(-1, -1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_settle", busy0, 1'b1);
    end
    tick();
    chk("t4_idle", busy0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_third", upd0, '0);
      chk("t4_still_idle", busy0, 1'b0);
    end
    chk("t4_attr_keep", attr0, e0);

    v1 = 1; idx1 = 0; a1 = 13'h1234;
    chk("t2_ready0", rdy1, 1'b1);
    tick();
    chk("t2_upd0", upd1, 12'h001);
    chk("t2_ready1", rdy1, 1'b1);
    idx1 = 1; a1 = 13'h0ABC;
    tick();
    chk("t2_upd1", upd1, 12'h002);
    chk("t2_ready2", rdy1, 1'b1);
    idx1 = 2; a1 = 13'h1555;
    tick();
    chk("t2_upd2", upd1, 12'h004);
    v1 = 0;
    tick();
    chk("t2_upd_clr", upd1, '0);
    e1[0*AW +: AW] = 13'h1234;
    e1[1*AW +: AW] = 13'h00BC;
    e1[2*AW +: AW] = 13'h1555;
    chk("t2_attr", attr1, e1);
    rdi1 = 1;
    #1;
    chk("t2_rd1", rda1, 13'h00BC);
    rdi1 = 13;
    #1;
    chk("t2_rd_oob", rda1, '0);

    v1 = 1; idx1 = 13; a1 = 13'h1FFF;
    tick();
    v1 = 0;
    chk("t5_upd", upd1, '0);
    chk("t5_attr", attr1, e1);
    chk("t5_err", err1, ErrOn);
    chk("t5_ready", rdy1, 1'b1);
    chk("t5_busy", busy1, 1'b0);
    tick();
    chk("t5_err_clr", err1, 1'b0);

    sw1 = 1;
    tick();
    sw1 = 0;
    chk("s0_ready", rdy1, 1'b0);
    tick();
    chk("s0_pre", upd1, '0);
    for (int p = 0; p < 12; p++) begin
      tick();
      chk("s0_strobe", upd1, 12'h1 << p);
    end
    chk("s0_idle", busy1, 1'b0);
    chk("s0_ready_back", rdy1, 1'b1);

    sw0 = 1;
    tick();
    sw0 = 0;
    tick();
    for (int p = 0; p < 8; p++) begin
      tick();
      chk("t6_strobe", upd0, 16'h1 << p);
    end
    rst_n = 1'b0;
    sw0 = 1;
    tick();
    sw0 = 0;
    rst_n = 1'b1;
    chk("t6_attr", attr0, '0);
    chk("t6_upd", upd0, '0);
    chk("t6_ready", rdy0, 1'b1);
    chk("t6_busy", busy0, 1'b0);
    chk("t6_attr1", attr1, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_pend", busy0, 1'b0);
      chk("t6_no_upd", upd0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
